// File: rtl/uart_pkg.sv
// Shared UART definitions: default line parameters and RX FSM state encoding.
package uart_pkg;

   localparam int unsigned UART_DEFAULT_CLK_FREQ = 50_000_000;
   localparam int unsigned UART_DEFAULT_BAUD     = 115_200;
   localparam int unsigned UART_OVERSAMPLE       = 16;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} uart_rx_state_t;

   // Clocks per oversample tick, truncated.
   function automatic int unsigned uart_div(input int unsigned clk_freq,
                                            input int unsigned baud,
                                            input int unsigned oversample);
      return clk_freq / (baud * oversample);
   endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Free-running divider: tick_o pulses for one clock every DIV clocks.
module uart_baud_tick_gen #(
   parameter int unsigned DIV = 27
) (
   input  logic clk_i,
   input  logic rstn_i,
   output logic tick_o
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick_o = (cnt_q == CW'(DIV - 1));
      cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: oversampled mid-bit sampling, sticky ready/frame_err/overrun flags.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = UART_DEFAULT_CLK_FREQ,
   parameter int unsigned BAUD       = UART_DEFAULT_BAUD,
   parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       rx_i,
   output logic [7:0] data_out_o,
   output logic       ready_o,
   input  logic       ready_clr_i,
   output logic       frame_err_o,
   output logic       overrun_o
);

   localparam int unsigned     DIV    = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int unsigned     SCW    = $clog2(OVERSAMPLE);
   localparam logic [SCW-1:0]  SC_MID = SCW'(OVERSAMPLE / 2 - 1);
   localparam logic [SCW-1:0]  SC_END = SCW'(OVERSAMPLE - 1);

   logic           tick;
   logic           rx_meta_q, rx_s_q;
   uart_rx_state_t state_q;
   logic [SCW-1:0] sc_q;
   logic [2:0]     bit_q;
   logic [7:0]     shreg_q;
   logic [7:0]     data_out_q;
   logic           ready_q, frame_err_q, overrun_q;

   uart_baud_tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .tick_o (tick)
   );

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= IDLE;
         sc_q        <= '0;
         bit_q       <= '0;
         shreg_q     <= '0;
         data_out_q  <= '0;
         ready_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         // Clear first so a same-cycle load or frame error below takes precedence.
         if (ready_clr_i) begin
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
         end
         unique case (state_q)
            IDLE: begin
               if (!rx_s_q) begin
                  state_q <= START;
                  sc_q    <= '0;
               end
            end
            START: begin
               if (tick) begin
                  if (sc_q == SC_MID) begin
                     if (rx_s_q) begin
                        state_q <= IDLE;
                     end else begin
                        sc_q    <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                     end
                  end else begin
                     sc_q <= sc_q + 1'b1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (sc_q == SC_END) begin
                     shreg_q <= {rx_s_q, shreg_q[7:1]};
                     sc_q    <= '0;
                     bit_q   <= bit_q + 1'b1;
                     if (bit_q == 3'd7) state_q <= STOP;
                  end else begin
                     sc_q <= sc_q + 1'b1;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  if (sc_q == SC_END) begin
                     if (rx_s_q) begin
                        data_out_q <= shreg_q;
                        ready_q    <= 1'b1;
                        overrun_q  <= !ready_clr_i && (overrun_q || ready_q);
                        state_q    <= IDLE;
                     end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= BRK;
                     end
                  end else begin
                     sc_q <= sc_q + 1'b1;
                  end
               end
            end
            BRK: begin
               if (rx_s_q) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data_out_o  = data_out_q;
   assign ready_o     = ready_q;
   assign frame_err_o = frame_err_q;
   assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at default parameters (432 clk per bit).
module tb_uart_rx_core;

   localparam int DIV = 27;
   localparam int BIT = 432;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       rx = 1'b1;
   logic       ready_clr = 1'b0;
   logic [7:0] data_out;
   logic       ready, frame_err, overrun;

   int errors = 0;
   int checks = 0;
   int tcnt;

   uart_rx_core dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .rx_i        (rx),
      .data_out_o  (data_out),
      .ready_o     (ready),
      .ready_clr_i (ready_clr),
      .frame_err_o (frame_err),
      .overrun_o   (overrun)
   );

   always #5 clk = ~clk;

   // Phase of the free-running oversample tick, counted from reset release.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) tcnt <= 0;
      else       tcnt <= (tcnt == DIV - 1) ? 0 : tcnt + 1;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic v, input int len);
      rx = v;
      repeat (len) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      drive_bit(1'b0, BIT);
      for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
      drive_bit(stop_bit, BIT);
      rx = 1'b1;
   endtask

   task automatic pulse_clr();
      ready_clr = 1'b1;
      @(negedge clk);
      ready_clr = 1'b0;
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("rst_data", data_out, 8'h00);
      check("rst_ready", {7'd0, ready}, 8'd0);
      check("rst_ferr", {7'd0, frame_err}, 8'd0);
      check("rst_ovr", {7'd0, overrun}, 8'd0);
      rstn = 1'b1;
      repeat (10) @(negedge clk);

      // 1: single byte, then clear
      send_frame(8'hBB, 1'b1);
      check("t1_ready", {7'd0, ready}, 8'd1);
      check("t1_data", data_out, 8'hBB);
      check("t1_ferr", {7'd0, frame_err}, 8'd0);
      pulse_clr();
      check("t1_clr", {7'd0, ready}, 8'd0);

      // 2: back-to-back frames
      send_frame(8'hCC, 1'b1);
      check("t2_ready0", {7'd0, ready}, 8'd1);
      check("t2_data0", data_out, 8'hCC);
      pulse_clr();
      send_frame(8'h01, 1'b1);
      check("t2_ready1", {7'd0, ready}, 8'd1);
      check("t2_data1", data_out, 8'h01);
      check("t2_ovr", {7'd0, overrun}, 8'd0);
      pulse_clr();

      // 3: short low glitch rejected, next byte fine
      drive_bit(1'b0, 100);
      drive_bit(1'b1, BIT);
      check("t3_ready", {7'd0, ready}, 8'd0);
      check("t3_ferr", {7'd0, frame_err}, 8'd0);
      check("t3_data_keep", data_out, 8'h01);
      send_frame(8'h5A, 1'b1);
      check("t3_data", data_out, 8'h5A);
      check("t3_ready2", {7'd0, ready}, 8'd1);
      pulse_clr();

      // 4: framing error, then recovery
      send_frame(8'hA5, 1'b0);
      check("t4_ferr", {7'd0, frame_err}, 8'd1);
      check("t4_ready", {7'd0, ready}, 8'd0);
      check("t4_data_keep", data_out, 8'h5A);
      drive_bit(1'b1, BIT);
      send_frame(8'h3C, 1'b1);
      check("t4_data", data_out, 8'h3C);
      check("t4_ready2", {7'd0, ready}, 8'd1);
      pulse_clr();

      // 5a: overrun
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      check("t5_ovr", {7'd0, overrun}, 8'd1);
      check("t5_data", data_out, 8'h22);
      pulse_clr();
      check("t5_ovr_clr", {7'd0, overrun}, 8'd0);

      // 5b: clear coinciding with the load edge (152nd tick after START entry)
      send_frame(8'h11, 1'b1);
      check("t5b_ready0", {7'd0, ready}, 8'd1);
      fork
         send_frame(8'h22, 1'b1);
         begin
            n = 0;
            repeat (3) @(posedge clk);
            while (n < 152) begin
               @(negedge clk);
               if (tcnt == DIV - 1) n++;
            end
            ready_clr = 1'b1;
            @(posedge clk);
            #1;
            check("t5b_data", data_out, 8'h22);
            check("t5b_ready", {7'd0, ready}, 8'd1);
            check("t5b_ovr", {7'd0, overrun}, 8'd0);
            ready_clr = 1'b0;
         end
      join
      check("t5b_ovr_after", {7'd0, overrun}, 8'd0);

      // 6: reset midway through data bit 3
      drive_bit(1'b0, BIT);
      drive_bit(1'b1, BIT);
      drive_bit(1'b0, BIT);
      drive_bit(1'b1, BIT);
      drive_bit(1'b0, BIT / 2);
      rstn = 1'b0;
      #1;
      check("t6_rst_data", data_out, 8'h00);
      check("t6_rst_ready", {7'd0, ready}, 8'd0);
      check("t6_rst_ferr", {7'd0, frame_err}, 8'd0);
      check("t6_rst_ovr", {7'd0, overrun}, 8'd0);
      rx = 1'b1;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (10) @(negedge clk);
      send_frame(8'h7E, 1'b1);
      check("t6_data", data_out, 8'h7E);
      check("t6_ready", {7'd0, ready}, 8'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
